// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM encoding,
// default bus widths and a width helper usable in parameter expressions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Never returns 0 so a 1-requester build still gets a legal index width.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_grant+1 with wrap-around.
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = clog2_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               any_req,
  output logic [IDW-1:0]     winner
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // One extra bit holds last_grant+i before the modulo fold.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, last_grant} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters,
// one transaction in flight, with a bus timeout that returns an error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16,
  localparam int IDW    = clog2_f(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready,
  output logic [IDW-1:0]            grant_id
);

  localparam logic [7:0]         TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
  localparam logic [IDW-1:0]     LAST_INIT = IDW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  arb_state_e          state, state_n;
  logic [IDW-1:0]      last_grant, last_grant_n, grant_id_n;
  logic [7:0]          cnt, cnt_n;
  logic [NUM_REQ-1:0]  ready_n, err_n;
  logic [DATA_W-1:0]   rdata_n, wdata_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                mem_req_n, mem_we_n;
  logic                any_req;
  logic [IDW-1:0]      winner;

  mem_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_INIT;
      cnt        <= '0;
      grant_id   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req_ready  <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      grant_id   <= grant_id_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      req_ready  <= ready_n;
      req_err    <= err_n;
      req_rdata  <= rdata_n;
    end
  end

  // Every output is registered; this block only computes next values.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    grant_id_n   = grant_id;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    addr_n       = mem_addr;
    wdata_n      = mem_wdata;
    ready_n      = '0;
    err_n        = '0;
    rdata_n      = req_rdata;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          addr_n     = addr_a[winner];
          wdata_n    = wdata_a[winner];
          mem_we_n   = req_we[winner];
          mem_req_n  = 1'b1;
          grant_id_n = winner;
          cnt_n      = '0;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_req_n    = 1'b0;
          mem_we_n     = 1'b0;
          rdata_n      = mem_we ? '0 : mem_rdata;
          ready_n      = ONE << grant_id;
          last_grant_n = grant_id;
          state_n      = RESP;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          mem_req_n    = 1'b0;
          mem_we_n     = 1'b0;
          rdata_n      = '0;
          ready_n      = ONE << grant_id;
          err_n        = ONE << grant_id;
          last_grant_n = grant_id;
          state_n      = RESP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      // Gap cycle so a requester dropping valid on ready is not re-granted.
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NUM_REQ=2, TIMEOUT=16) with a small
// latency-programmable memory responder.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, req_err;
  logic [15:0] req_addr, req_wdata;
  logic [7:0]  req_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_req, mem_we;
  logic        mem_ready = 1'b0;
  logic [0:0]  grant_id;

  int n_vec = 0;
  int n_err = 0;
  int ready_on = 1;   // BUSY cycle on which mem_ready is raised; 0 = never
  int wait_cnt = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant_id  (grant_id)
  );

  always @(negedge clk) begin
    if (mem_req !== 1'b1) begin
      wait_cnt  = 0;
      mem_ready = 1'b0;
    end else begin
      wait_cnt++;
      mem_ready = (ready_on > 0 && wait_cnt == ready_on);
    end
    mem_rdata = mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (req_ready == 2'b00 && cyc < max_cyc);
    chk("ready_seen", 32'(req_ready != 2'b00), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   exp_id;
    logic bad;

    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h33;
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h5A;

    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_err", req_err, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    tick();
    chk("idle_no_req", mem_req, 0);

    // single read, mem_ready on 2nd BUSY cycle
    ready_on = 2; req_valid = 2'b01; req_addr[7:0] = 8'h10;
    tick();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 8'h10);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_gid", grant_id, 0);
    tick();
    chk("rd_wait_ready", req_ready, 0);
    chk("rd_wait_req", mem_req, 1);
    tick();
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_rdata", req_rdata, 8'hA5);
    chk("rd_err", req_err, 0);
    chk("rd_req_drop", mem_req, 0);
    req_valid = 2'b00;
    tick();
    chk("rd_ready_clr", req_ready, 0);

    // write from requester 1
    ready_on = 1; req_valid = 2'b10; req_we = 2'b10;
    req_addr[15:8] = 8'h3C; req_wdata[15:8] = 8'h7E;
    tick();
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h3C);
    chk("wr_mem_wdata", mem_wdata, 8'h7E);
    chk("wr_gid", grant_id, 1);
    tick();
    chk("wr_ready", req_ready, 2'b10);
    chk("wr_err", req_err, 0);
    chk("wr_rdata", req_rdata, 0);
    chk("wr_we_clr", mem_we, 0);
    req_valid = 2'b00; req_we = 2'b00;
    tick();

    // fairness: both held, zero-wait memory, last grant was 1
    req_addr = {8'h20, 8'h10}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ready(10, cyc);
      exp_id = k % 2;
      chk("rr_ready", req_ready, 2'b01 << exp_id);
      chk("rr_gid", grant_id, exp_id);
      chk("rr_rdata", req_rdata, (exp_id == 0) ? 8'hA5 : 8'h5A);
      if (k > 0) chk("rr_spacing", cyc, 3);
    end
    req_valid = 2'b00;
    tick(); tick();

    // timeout on requester 0 while requester 1 waits
    ready_on = 0; req_valid = 2'b11;
    tick();
    chk("to_gid", grant_id, 0);
    chk("to_mem_req", mem_req, 1);
    bad = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (mem_req !== 1'b1 || req_ready !== 2'b00) bad = 1'b1;
    end
    chk("to_hold", bad, 0);
    tick();
    chk("to_req_drop", mem_req, 0);
    chk("to_ready", req_ready, 2'b01);
    chk("to_err", req_err, 2'b01);
    chk("to_rdata", req_rdata, 0);
    req_valid = 2'b10; ready_on = 1;
    tick();
    chk("to_resp_ready", req_ready, 0);
    chk("to_resp_err", req_err, 0);
    tick();
    chk("to_next_gid", grant_id, 1);
    chk("to_next_req", mem_req, 1);
    tick();
    chk("to_next_ready", req_ready, 2'b10);
    chk("to_next_err", req_err, 0);
    chk("to_next_rdata", req_rdata, 8'h5A);
    req_valid = 2'b00;
    tick();

    // stale-request guard: requester 0 drops valid on its ready
    req_valid = 2'b01;
    tick();
    chk("st_gid", grant_id, 0);
    tick();
    chk("st_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_no_regrant", mem_req, 0);
    end

    // reset mid-transaction while requester 1 is in BUSY
    ready_on = 0; req_valid = 2'b10;
    tick();
    chk("rm_gid", grant_id, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rm_mem_req", mem_req, 0);
    chk("rm_ready", req_ready, 0);
    chk("rm_gid_clr", grant_id, 0);
    rst = 1'b0; req_valid = 2'b11; ready_on = 1;
    tick();
    chk("rm_first_gid", grant_id, 0);
    chk("rm_first_addr", mem_addr, 8'h10);
    tick();
    chk("rm_first_ready", req_ready, 2'b01);
    chk("rm_first_rdata", req_rdata, 8'hA5);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
